multi_table_stream_decoder: RTL and testbench

Next-generation table-driven variable-length (Huffman-style) stream decoder. It has an internal bit buffer, NUM_TABLES independently loadable code tables selectable per decode, an output FIFO with valid/pop handshake, a sticky invalid-code error, and a flush. It sits between the packed input word stream and symbol consumers in the decompression path.

---
 rtl/multi_table_stream_decoder.sv | 195 +++++++++++++++++++
 tb/tb_multi_table_stream_decoder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_table_stream_decoder.sv
// multi_table_stream_decoder: table-driven variable-length code decoder with a
// bit buffer, NUM_TABLES loadable code tables, an output FIFO, sticky error and flush.
// Optional escape/literal support is enabled by defining STREAM_DECODER_ESCAPE_EN.
module multi_table_stream_decoder #(
  parameter int WIDTH_IN             = 64,
  parameter int WIDTH_OUT            = 8,
  parameter int MAX_CODE_LENGTH      = 9,
  parameter int LOG2_MAX_CODE_LENGTH = $clog2(MAX_CODE_LENGTH + 1),
  parameter int NUM_TABLES           = 2,
  parameter int LOG2_NUM_TABLES      = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1,
  parameter int BUF_BITS             = 2 * WIDTH_IN,
  parameter int OUT_DEPTH            = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [WIDTH_IN-1:0]             d,
  output logic                            full,
  input  logic                            flush,
  input  logic [LOG2_NUM_TABLES-1:0]      active_table,
  input  logic                            table_push,
  input  logic [LOG2_NUM_TABLES-1:0]      table_sel,
  input  logic [MAX_CODE_LENGTH-1:0]      table_addr,
  input  logic [LOG2_MAX_CODE_LENGTH-1:0] table_code_width,
  input  logic                            table_escape,
  input  logic [WIDTH_OUT-1:0]            table_data,
  output logic [WIDTH_OUT-1:0]            q,
  output logic                            valid,
  input  logic                            pop,
  output logic                            error
);

  localparam int DEPTH = 1 << MAX_CODE_LENGTH;
  localparam int CNT_W = $clog2(BUF_BITS + 1);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int OCC_W = $clog2(OUT_DEPTH + 1);

  typedef enum logic [0:0] {
    DECODE  = 1'b0,
    LITERAL = 1'b1
  } state_t;

`ifdef STREAM_DECODER_ESCAPE_EN
  typedef struct packed {
    logic [LOG2_MAX_CODE_LENGTH-1:0] width;
    logic                            escape;
    logic [WIDTH_OUT-1:0]            data;
  } entry_t;
`else
  typedef struct packed {
    logic [LOG2_MAX_CODE_LENGTH-1:0] width;
    logic [WIDTH_OUT-1:0]            data;
  } entry_t;

  // Escape flag has no meaning without literal support, so it is not stored.
  logic unused_escape;
  assign unused_escape = table_escape;
`endif

  state_t               state_q, state_d;
  logic [BUF_BITS-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 error_q, error_d;
  logic [CNT_W-1:0]     consume, remain;

  entry_t               table_mem [NUM_TABLES][DEPTH];
  entry_t               wr_entry;
  entry_t               rd_entry;

  logic [WIDTH_OUT-1:0] fifo_mem [OUT_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [OCC_W-1:0]     occ_q;
  logic                 fifo_full, fifo_wr, do_pop;
  logic [WIDTH_OUT-1:0] fifo_wdata;

  logic                 push_ok, dec_fire, lit_fire;

  // Pack the incoming table entry fields into one RAM word.
  always_comb begin
    wr_entry       = '0;
    wr_entry.width = table_code_width;
    wr_entry.data  = table_data;
`ifdef STREAM_DECODER_ESCAPE_EN
    wr_entry.escape = table_escape;
`endif
  end

  // Code table RAM write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (table_push) table_mem[table_sel][table_addr] <= wr_entry;
  end

  assign rd_entry = table_mem[active_table][buf_q[MAX_CODE_LENGTH-1:0]];

  assign full     = count_q > CNT_W'(BUF_BITS - WIDTH_IN);
  assign push_ok  = push && !full && !flush;
  assign dec_fire = (state_q == DECODE) && (count_q >= CNT_W'(MAX_CODE_LENGTH)) &&
                    !fifo_full && !error_q && !table_push && !flush;
`ifdef STREAM_DECODER_ESCAPE_EN
  assign lit_fire = (state_q == LITERAL) && (count_q >= CNT_W'(WIDTH_OUT)) &&
                    !fifo_full && !table_push && !flush;
`else
  assign lit_fire = 1'b0;
`endif

  // Next-state logic: decode or literal consume, buffer shift and append, error and flush.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    count_d    = count_q;
    error_d    = error_q;
    fifo_wr    = 1'b0;
    fifo_wdata = '0;
    consume    = '0;
    remain     = count_q;
    if (flush) begin
      state_d = DECODE;
      buf_d   = '0;
      count_d = '0;
      error_d = 1'b0;
    end else begin
      if (dec_fire) begin
        if (rd_entry.width == '0) begin
          error_d = 1'b1;
`ifdef STREAM_DECODER_ESCAPE_EN
        end else if (rd_entry.escape) begin
          consume = CNT_W'(rd_entry.width);
          state_d = LITERAL;
`endif
        end else begin
          consume    = CNT_W'(rd_entry.width);
          fifo_wr    = 1'b1;
          fifo_wdata = rd_entry.data;
        end
      end else if (lit_fire) begin
        consume    = CNT_W'(WIDTH_OUT);
        fifo_wr    = 1'b1;
        fifo_wdata = buf_q[WIDTH_OUT-1:0];
        state_d    = DECODE;
      end
      remain  = count_q - consume;
      buf_d   = buf_q >> consume;
      count_d = remain;
      if (push_ok) begin
        buf_d   = buf_d | (BUF_BITS'(d) << remain);
        count_d = remain + CNT_W'(WIDTH_IN);
      end
    end
  end

  // State, bit buffer and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DECODE;
      buf_q   <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;

  assign valid     = occ_q != '0;
  assign fifo_full = occ_q == OCC_W'(OUT_DEPTH);
  assign do_pop    = pop && valid;
  assign q         = valid ? fifo_mem[rd_ptr] : '0;

  // Output FIFO storage; only the slot being written changes.
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= fifo_wdata;
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({fifo_wr, do_pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_table_stream_decoder.sv
// tb_multi_table_stream_decoder: directed scoreboard bench for multi_table_stream_decoder.
module tb_multi_table_stream_decoder;

  logic        clk;
  logic        rst;
  logic        push;
  logic [63:0] d;
  logic        full;
  logic        flush;
  logic [0:0]  active_table;
  logic        table_push;
  logic [0:0]  table_sel;
  logic [8:0]  table_addr;
  logic [3:0]  table_code_width;
  logic        table_escape;
  logic [7:0]  table_data;
  logic [7:0]  q;
  logic        valid;
  logic        pop;
  logic        error;

  logic [7:0]  exp_q [$];
  logic [7:0]  exp_sym;
  logic [63:0] word3;
  int          checks = 0;
  int          failures = 0;
  int          run_len;

  multi_table_stream_decoder dut (
    .clk              (clk),
    .rst              (rst),
    .push             (push),
    .d                (d),
    .full             (full),
    .flush            (flush),
    .active_table     (active_table),
    .table_push       (table_push),
    .table_sel        (table_sel),
    .table_addr       (table_addr),
    .table_code_width (table_code_width),
    .table_escape     (table_escape),
    .table_data       (table_data),
    .q                (q),
    .valid            (valid),
    .pop              (pop),
    .error            (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Scoreboard monitor: each symbol accepted by a pop is compared with the oldest expected one.
  always @(negedge clk) begin
    if (rst && valid && pop) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_symbol actual=%02h required=none", q);
      end else begin
        exp_sym = exp_q.pop_front();
        checkOutput("symbol", 64'(q), 64'(exp_sym));
      end
    end
  end

  task automatic expectRepeat(input logic [7:0] sym, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(sym);
  endtask

  task automatic applyStimulus(input logic [63:0] word);
    @(posedge clk); #1;
    push = 1'b1;
    d    = word;
    @(posedge clk); #1;
    push = 1'b0;
    d    = '0;
  endtask

  task automatic flushBuffer();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic writeEntry(input logic [0:0] sel, input logic [8:0] addr, input logic [3:0] width,
                            input logic esc, input logic [7:0] data);
    @(posedge clk); #1;
    table_push       = 1'b1;
    table_sel        = sel;
    table_addr       = addr;
    table_code_width = width;
    table_escape     = esc;
    table_data       = data;
  endtask

  task automatic endTableWrite();
    @(posedge clk); #1;
    table_push = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int cycles;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      @(posedge clk);
      cycles++;
    end
    repeat (6) @(posedge clk);
    #1;
    checkOutput({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Watchdog so a stuck run still ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; push = 1'b0; d = '0; flush = 1'b0; active_table = '0;
    table_push = 1'b0; table_sel = '0; table_addr = '0; table_code_width = '0;
    table_escape = 1'b0; table_data = '0; pop = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", 64'(valid), 64'd0);
    checkOutput("reset_q", 64'(q), 64'd0);
    checkOutput("reset_full", 64'(full), 64'd0);
    checkOutput("reset_error", 64'(error), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Table 0: even codes width 1 -> 0x41, odd codes width 2 -> 0x42.
    for (int i = 0; i < 512; i++)
      writeEntry(1'b0, 9'(i), i[0] ? 4'd2 : 4'd1, 1'b0, i[0] ? 8'h42 : 8'h41);
    // Table 1: every code width 9, symbol equals low address byte.
    for (int i = 0; i < 512; i++)
      writeEntry(1'b1, 9'(i), 4'd9, 1'b0, i[7:0]);
    endTableWrite();

    // Test 1: all-zero word gives 56 symbols, the 8 leftover bits join the next word.
    $display("[TB] test 1: zero stream");
    pop = 1'b1;
    expectRepeat(8'h41, 56);
    applyStimulus(64'h0);
    waitDrain("t1_first_word", 200);
    @(negedge clk);
    checkOutput("t1_stalled_valid", 64'(valid), 64'd0);
    expectRepeat(8'h41, 64);
    applyStimulus(64'h0);
    waitDrain("t1_second_word", 200);
    flushBuffer();

    // Test 2: alternating bits give 0x42 each cycle, first valid two cycles after push.
    $display("[TB] test 2: latency and throughput");
    expectRepeat(8'h42, 28);
    applyStimulus(64'h5555_5555_5555_5555);
    @(negedge clk);
    checkOutput("t2_valid_cycle1", 64'(valid), 64'd0);
    @(negedge clk);
    checkOutput("t2_valid_cycle2", 64'(valid), 64'd1);
    run_len = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!valid) break;
      run_len++;
    end
    checkOutput("t2_valid_run", 64'(run_len), 64'd28);
    waitDrain("t2_stream", 50);
    flushBuffer();

    // Test 3: four table-0 symbols fill the FIFO, then table 1 decodes the rest.
    $display("[TB] test 3: table switch");
    pop = 1'b0;
    word3 = (64'h1A3 << 4) | (64'h05C << 13) | (64'h0FF << 22) |
            (64'h100 << 31) | (64'h012 << 40) | (64'h1FE << 49);
    expectRepeat(8'h41, 4);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h5C);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'hFE);
    applyStimulus(word3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("t3_stalled_valid", 64'(valid), 64'd1);
    @(posedge clk); #1;
    active_table = 1'b1;
    @(posedge clk); #1;
    pop = 1'b1;
    waitDrain("t3_table_switch", 100);
    active_table = 1'b0;
    flushBuffer();

    // Test 4: three back-to-back pushes, third refused while full, nothing lost.
    $display("[TB] test 4: full and backpressure");
    pop = 1'b0;
    expectRepeat(8'h41, 120);
    @(posedge clk); #1; push = 1'b1; d = 64'h0;
    @(posedge clk); #1; d = 64'h0;
    @(posedge clk); #1; d = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1; push = 1'b0; d = '0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkOutput("t4_full", 64'(full), 64'd1);
    checkOutput("t4_valid", 64'(valid), 64'd1);
    @(posedge clk); #1;
    pop = 1'b1;
    waitDrain("t4_no_loss", 400);
    flushBuffer();

    // Test 5: width-0 entry raises error; flush clears it and keeps FIFO contents.
    $display("[TB] test 5: invalid code and flush");
    pop = 1'b0;
    writeEntry(1'b0, 9'h1FF, 4'd0, 1'b0, 8'h00);
    endTableWrite();
    expectRepeat(8'h41, 2);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFC);
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkOutput("t5_error_set", 64'(error), 64'd1);
    checkOutput("t5_valid_held", 64'(valid), 64'd1);
    flushBuffer();
    @(negedge clk);
    checkOutput("t5_error_cleared", 64'(error), 64'd0);
    checkOutput("t5_fifo_kept", 64'(valid), 64'd1);
    @(posedge clk); #1;
    pop = 1'b1;
    waitDrain("t5_fifo_retained", 50);
    writeEntry(1'b0, 9'h1FF, 4'd2, 1'b0, 8'h42);
    endTableWrite();
    expectRepeat(8'h41, 56);
    applyStimulus(64'h0);
    waitDrain("t5_count_cleared", 200);
    flushBuffer();

`ifdef STREAM_DECODER_ESCAPE_EN
    // Test 6: escape on odd codes passes the next 8 bits raw; reset mid-literal.
    $display("[TB] test 6: escape literal");
    for (int i = 0; i < 512; i++)
      writeEntry(1'b0, 9'(i), 4'd1, i[0], i[0] ? 8'h00 : 8'h41);
    endTableWrite();
    exp_q.push_back(8'hA5);
    expectRepeat(8'h41, 47);
    applyStimulus(64'h14B);
    waitDrain("t6_literal", 200);
    flushBuffer();
    pop = 1'b0;
    @(posedge clk); #1; push = 1'b1; d = 64'h2;
    @(posedge clk); #1; d = 64'h0;
    @(posedge clk); #1; push = 1'b0;
    @(posedge clk); #1;
    checkOutput("t6_pre_reset_valid", 64'(valid), 64'd1);
    checkOutput("t6_pre_reset_full", 64'(full), 64'd1);
    #1 rst = 1'b0;
    #1;
    checkOutput("t6_reset_valid", 64'(valid), 64'd0);
    checkOutput("t6_reset_q", 64'(q), 64'd0);
    checkOutput("t6_reset_full", 64'(full), 64'd0);
    checkOutput("t6_reset_error", 64'(error), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    pop = 1'b1;
    expectRepeat(8'h41, 56);
    applyStimulus(64'h0);
    waitDrain("t6_after_reset", 200);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
